ycr_sleep_seq: RTL

- Sleep sequencer between the RISC-V CSR sleep command and the source clock-gate cell (ycr_clk_gate2-style gate).
- Accepts a sleep request, drains outstanding bus traffic, and derives the gate wake mode from a wake mask.
- Drives the gate's `cfg_mode` and `dst_idle`, tracks the wake-up handshake, and reports wake cause and sleep duration.
- Runs on the free-running (ungated) `clk_in`.

---
 rtl/ycr_sleep_seq_if.sv | 30 +++
 rtl/ycr_sleep_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ycr_sleep_seq_if.sv
// Signal bundle between the sleep sequencer, its CSR/bus side and the clock-gate cell.
// The slave side is the sequencer; the master side is whoever drives requests and gate status.
interface ycr_sleep_seq_if #(
  parameter int CNT_W = 16
) ();
  logic             sleep_req;
  logic [2:0]       cfg_wake_mask;
  logic [3:0]       cfg_guard;
  logic             bus_busy;
  logic [2:0]       irq;
  logic             gate_wakeup;
  logic             gate_clk_enb;
  logic [2:0]       cfg_mode;
  logic             dst_idle;
  logic             sleep_done;
  logic             sleep_err;
  logic [2:0]       wake_cause;
  logic [CNT_W-1:0] sleep_cnt;
  logic [2:0]       seq_state;

  modport master (
    output sleep_req, cfg_wake_mask, cfg_guard, bus_busy, irq, gate_wakeup, gate_clk_enb,
    input  cfg_mode, dst_idle, sleep_done, sleep_err, wake_cause, sleep_cnt, seq_state
  );

  modport slave (
    input  sleep_req, cfg_wake_mask, cfg_guard, bus_busy, irq, gate_wakeup, gate_clk_enb,
    output cfg_mode, dst_idle, sleep_done, sleep_err, wake_cause, sleep_cnt, seq_state
  );
endinterface

// File: rtl/ycr_sleep_seq.sv
// Sleep sequencer: drains bus traffic, programs the clock-gate wake mode, drives dst_idle
// and tracks the wake handshake. Runs on the free-running clk_in.
module ycr_sleep_seq #(
  parameter int DRAIN_TMO = 64,
  parameter int CNT_W     = 16
) (
  input logic             clk_in,
  input logic             reset_n,
  ycr_sleep_seq_if.slave  io_seq
);

  localparam int DCNT_W = (DRAIN_TMO > 1) ? $clog2(DRAIN_TMO) : 1;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_GUARD = 3'd2,
    ST_SLEEP = 3'd3,
    ST_WAKE  = 3'd4
  } state_t;

  function automatic logic [2:0] mode_map(input logic [2:0] mask);
    case (mask)
      3'b000:  mode_map = 3'b000;
      3'b001:  mode_map = 3'b001;
      3'b010:  mode_map = 3'b010;
      3'b100:  mode_map = 3'b011;
      default: mode_map = 3'b100;
    endcase
  endfunction

  state_t              r_state;
  logic [2:0]          r_mask;
  logic [2:0]          r_cfg_mode;
  logic                r_dst_idle;
  logic                r_sleep_done;
  logic                r_sleep_err;
  logic [2:0]          r_wake_cause;
  logic [CNT_W-1:0]    r_sleep_cnt;
  logic [DCNT_W-1:0]   r_drain_cnt;
  logic [3:0]          r_guard_cnt;

  state_t              w_state_nxt;
  logic [2:0]          w_mask_nxt;
  logic [2:0]          w_cfg_mode_nxt;
  logic                w_dst_idle_nxt;
  logic                w_sleep_done_nxt;
  logic                w_sleep_err_nxt;
  logic [2:0]          w_wake_cause_nxt;
  logic [CNT_W-1:0]    w_sleep_cnt_nxt;
  logic [DCNT_W-1:0]   w_drain_cnt_nxt;
  logic [3:0]          w_guard_cnt_nxt;
  logic                w_irq_hit;
  logic                w_guard_done;

  assign w_irq_hit = |(io_seq.irq & r_mask);

  // GUARD dwells max(cfg_guard, 2) cycles so the gate's mode synchroniser settles first.
  assign w_guard_done = (r_guard_cnt != 4'd0) &&
                        (({1'b0, r_guard_cnt} + 5'd1) >= {1'b0, io_seq.cfg_guard});

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    w_state_nxt      = r_state;
    w_mask_nxt       = r_mask;
    w_cfg_mode_nxt   = r_cfg_mode;
    w_dst_idle_nxt   = r_dst_idle;
    w_sleep_done_nxt = 1'b0;
    w_sleep_err_nxt  = 1'b0;
    w_wake_cause_nxt = r_wake_cause;
    w_sleep_cnt_nxt  = r_sleep_cnt;
    w_drain_cnt_nxt  = r_drain_cnt;
    w_guard_cnt_nxt  = r_guard_cnt;

    case (r_state)
      ST_RUN: begin
        w_dst_idle_nxt = 1'b0;
        w_cfg_mode_nxt = 3'b000;
        if (io_seq.sleep_req) begin
          if (io_seq.cfg_wake_mask == 3'b000) begin
            w_sleep_err_nxt = 1'b1;
          end else begin
            w_state_nxt     = ST_DRAIN;
            w_mask_nxt      = io_seq.cfg_wake_mask;
            w_cfg_mode_nxt  = mode_map(io_seq.cfg_wake_mask);
            w_drain_cnt_nxt = '0;
          end
        end
      end

      ST_DRAIN: begin
        if (w_irq_hit) begin
          w_state_nxt      = ST_RUN;
          w_cfg_mode_nxt   = 3'b000;
          w_sleep_err_nxt  = 1'b1;
          w_wake_cause_nxt = io_seq.irq & r_mask;
        end else if (io_seq.bus_busy && (r_drain_cnt == DCNT_W'(DRAIN_TMO - 1))) begin
          w_state_nxt     = ST_RUN;
          w_cfg_mode_nxt  = 3'b000;
          w_sleep_err_nxt = 1'b1;
        end else if (!io_seq.bus_busy) begin
          w_state_nxt     = ST_GUARD;
          w_guard_cnt_nxt = 4'd0;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + DCNT_W'(1);
        end
      end

      ST_GUARD: begin
        if (w_irq_hit) begin
          w_state_nxt      = ST_RUN;
          w_cfg_mode_nxt   = 3'b000;
          w_sleep_err_nxt  = 1'b1;
          w_wake_cause_nxt = io_seq.irq & r_mask;
        end else if (w_guard_done) begin
          w_state_nxt     = ST_SLEEP;
          w_dst_idle_nxt  = 1'b1;
          w_sleep_cnt_nxt = '0;
        end else begin
          w_guard_cnt_nxt = r_guard_cnt + 4'd1;
        end
      end

      ST_SLEEP: begin
        w_dst_idle_nxt = 1'b1;
        if (r_sleep_cnt != {CNT_W{1'b1}}) begin
          w_sleep_cnt_nxt = r_sleep_cnt + CNT_W'(1);
        end
        // The gate decides when to wake; irq alone is only recorded as the cause.
        if (io_seq.gate_wakeup) begin
          w_state_nxt      = ST_WAKE;
          w_dst_idle_nxt   = 1'b0;
          w_wake_cause_nxt = io_seq.irq;
        end
      end

      ST_WAKE: begin
        if (io_seq.gate_clk_enb) begin
          w_state_nxt      = ST_RUN;
          w_cfg_mode_nxt   = 3'b000;
          w_sleep_done_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt    = ST_RUN;
        w_cfg_mode_nxt = 3'b000;
        w_dst_idle_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_RUN;
      r_mask       <= 3'b000;
      r_cfg_mode   <= 3'b000;
      r_dst_idle   <= 1'b0;
      r_sleep_done <= 1'b0;
      r_sleep_err  <= 1'b0;
      r_wake_cause <= 3'b000;
      r_sleep_cnt  <= '0;
      r_drain_cnt  <= '0;
      r_guard_cnt  <= 4'd0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      r_state      <= w_state_nxt;
      r_mask       <= w_mask_nxt;
      r_cfg_mode   <= w_cfg_mode_nxt;
      r_dst_idle   <= w_dst_idle_nxt;
      r_sleep_done <= w_sleep_done_nxt;
      r_sleep_err  <= w_sleep_err_nxt;
      r_wake_cause <= w_wake_cause_nxt;
      r_sleep_cnt  <= w_sleep_cnt_nxt;
      r_drain_cnt  <= w_drain_cnt_nxt;
      r_guard_cnt  <= w_guard_cnt_nxt;
    end
  end

  assign io_seq.cfg_mode   = r_cfg_mode;
  assign io_seq.dst_idle   = r_dst_idle;
  assign io_seq.sleep_done = r_sleep_done;
  assign io_seq.sleep_err  = r_sleep_err;
  assign io_seq.wake_cause = r_wake_cause;
  assign io_seq.sleep_cnt  = r_sleep_cnt;
  assign io_seq.seq_state  = r_state;

endmodule
